// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC zone controller: zone state enum,
// comparator input codes and actuator output codes.
package hvac_pkg;

    // Zone state; the numeric values double as the state_display encoding.
    typedef enum logic [1:0] {
        OFF      = 2'd0,
        DECREASE = 2'd1,
        INCREASE = 2'd2,
        IDLE     = 2'd3
    } state_t;

    // Per-zone temperature comparator codes.
    localparam logic [1:0] TEMP_ON_TARGET = 2'b00;
    localparam logic [1:0] TEMP_COLD      = 2'b01;
    localparam logic [1:0] TEMP_HOT       = 2'b10;
    localparam logic [1:0] TEMP_INVALID   = 2'b11;

    // Per-zone actuator codes.
    localparam logic [1:0] ACT_IDLE     = 2'b00;
    localparam logic [1:0] ACT_DECREASE = 2'b01;
    localparam logic [1:0] ACT_INCREASE = 2'b10;
    localparam logic [1:0] ACT_OFF      = 2'b11;

    // Actuator code driven while a zone sits in the given state.
    function automatic logic [1:0] action_code(state_t s);
        logic [1:0] code;
        code = ACT_OFF;
        case (s)
            OFF:      code = ACT_OFF;
            DECREASE: code = ACT_DECREASE;
            INCREASE: code = ACT_INCREASE;
            IDLE:     code = ACT_IDLE;
            default:  code = ACT_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hvac_zone_fsm.sv
// One climate zone: OFF/DECREASE/INCREASE/IDLE state machine with a
// minimum-dwell counter for heating/cooling episodes.
// Optional sticky invalid-input flag when HVAC_FAULT_DETECT_EN is defined.
module hvac_zone_fsm
    import hvac_pkg::*;
#(
    parameter int DWELL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power,
    input  logic [1:0] temp_comp,
    output logic [1:0] action,
    output logic [1:0] state_display,
    output logic       active
`ifdef HVAC_FAULT_DETECT_EN
    ,
    output logic       fault
`endif
);

    // DWELL_CYCLES=1 would give a zero-width counter, so keep at least one bit;
    // with CNT_MAX=0 the dwell is then satisfied immediately.
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] dwell_cnt;
    logic             dwell_done;

    assign dwell_done = (dwell_cnt == CNT_MAX);

    // Zone state and dwell counter; losing power overrides everything except reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= OFF;
            dwell_cnt <= '0;
        end else if (!power) begin
            state <= OFF;
        end else begin
            case (state)
                OFF, IDLE: begin
                    if (temp_comp == TEMP_HOT) begin
                        state     <= DECREASE;
                        dwell_cnt <= '0;
                    end else if (temp_comp == TEMP_COLD) begin
                        state     <= INCREASE;
                        dwell_cnt <= '0;
                    end else if (temp_comp == TEMP_ON_TARGET) begin
                        state <= IDLE;
                    end
                end
                DECREASE: begin
                    if ((temp_comp == TEMP_ON_TARGET || temp_comp == TEMP_COLD) && dwell_done) begin
                        state <= IDLE;
                    end else if (!dwell_done) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                INCREASE: begin
                    if ((temp_comp == TEMP_ON_TARGET || temp_comp == TEMP_HOT) && dwell_done) begin
                        state <= IDLE;
                    end else if (!dwell_done) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

`ifdef HVAC_FAULT_DETECT_EN
    // Sticky flag for an invalid comparator code seen while powered; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (power && temp_comp == TEMP_INVALID) begin
            fault <= 1'b1;
        end
    end
`endif

    assign state_display = state;
    assign action        = action_code(state);
    assign active        = (state == DECREASE) || (state == INCREASE);

endmodule

// File: rtl/hvac_zone_controller.sv
// Multi-zone HVAC controller: one independent hvac_zone_fsm per zone plus an
// any-zone-active summary. Define HVAC_FAULT_DETECT_EN to add the fault port.
module hvac_zone_controller #(
    parameter int NUM_ZONES    = 4,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ZONES-1:0]   power,
    input  logic [2*NUM_ZONES-1:0] temp_comp,
    output logic [2*NUM_ZONES-1:0] action,
    output logic [2*NUM_ZONES-1:0] state_display,
    output logic                   any_active
`ifdef HVAC_FAULT_DETECT_EN
    ,
    output logic [NUM_ZONES-1:0]   fault
`endif
);

    logic [NUM_ZONES-1:0] zone_active;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        hvac_zone_fsm #(
            .DWELL_CYCLES(DWELL_CYCLES)
        ) u_zone (
            .clk           (clk),
            .reset         (reset),
            .power         (power[z]),
            .temp_comp     (temp_comp[2*z +: 2]),
            .action        (action[2*z +: 2]),
            .state_display (state_display[2*z +: 2]),
            .active        (zone_active[z])
`ifdef HVAC_FAULT_DETECT_EN
            ,
            .fault         (fault[z])
`endif
        );
    end

    assign any_active = |zone_active;

endmodule

// File: doc/hvac_zone_controller.md
HVAC_ZONE_CONTROLLER -- requirements
Module: hvac_zone_controller

Interface
REQ-001 Parameter NUM_ZONES, default 4: number of independent climate zones; legal range 1..16.
REQ-002 Parameter DWELL_CYCLES, default 8: minimum clock cycles a zone SHALL stay in DECREASE or INCREASE; legal range 1..1023.
REQ-003 clk  input  1  single rising-edge clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 power  input  NUM_ZONES  per-zone enable; bit z controls zone z.
REQ-006 temp_comp  input  2*NUM_ZONES  per-zone comparator; bits [2z+1:2z]: 10 too hot, 01 too cold, 00 on target, 11 invalid.
REQ-007 action  output  2*NUM_ZONES  per-zone actuator code: OFF 11, DECREASE 01, INCREASE 10, IDLE 00.
REQ-008 state_display  output  2*NUM_ZONES  per-zone current state encoding: OFF 0, DECREASE 1, INCREASE 2, IDLE 3.
REQ-009 any_active  output  1  high when at least one zone is in DECREASE or INCREASE.
REQ-010 fault  output  NUM_ZONES  per-zone sticky invalid-input flag; present only per REQ-027.

Function
REQ-011 Each zone SHALL run an independent 4-state FSM (OFF, DECREASE, INCREASE, IDLE), registered on clk; zones SHALL NOT interact.
REQ-012 power[z]=0 SHALL force zone z to OFF on the next edge from any state, overriding dwell.
REQ-013 OFF with power=1: 10->DECREASE, 01->INCREASE, 00->IDLE, 11->stay OFF.
REQ-014 IDLE with power=1: 10->DECREASE, 01->INCREASE, 00 or 11->stay IDLE.
REQ-015 DECREASE with power=1: 10 or 11->stay; 00 or 01->IDLE, only when dwell is satisfied, else stay.
REQ-016 INCREASE with power=1: 01 or 11->stay; 00 or 10->IDLE, only when dwell is satisfied, else stay.
REQ-017 Direct DECREASE<->INCREASE transitions SHALL never occur; a reversal always passes through IDLE for at least one cycle.
REQ-018 Per-zone dwell counter, width clog2(DWELL_CYCLES): cleared on the edge entering DECREASE/INCREASE, +1 per cycle in that state, saturating at DWELL_CYCLES-1.
REQ-019 Dwell is satisfied when the counter equals DWELL_CYCLES-1, so a heating/cooling episode lasts at least DWELL_CYCLES cycles; DWELL_CYCLES=1 imposes no delay.
REQ-020 action, state_display and any_active SHALL be combinational decodes of the registered states: zero-cycle latency from state, one-cycle latency from inputs.
REQ-021 Counter value outside DECREASE/INCREASE is don't-care; it is never read there.

Reset
REQ-022 reset=1 at a clock edge SHALL put every zone in OFF and clear every dwell counter, overriding power and temp_comp.
REQ-023 After reset: action all 11, state_display all 0, any_active 0, fault all 0.
REQ-024 Reset asserted mid-dwell SHALL abort the episode; the first post-reset DECREASE/INCREASE entry starts a fresh dwell count.

Configuration
REQ-025 Macro HVAC_FAULT_DETECT_EN selects invalid-input fault tracking.
REQ-026 With HVAC_FAULT_DETECT_EN defined: fault[z] sets on any edge where power[z]=1 and temp_comp for z is 11; it is cleared only by reset; it does not alter FSM transitions.
REQ-027 Without HVAC_FAULT_DETECT_EN: the fault port SHALL be absent and no fault logic SHALL be synthesised; all other behaviour is identical.

Structure
REQ-028 Shared package hvac_pkg SHALL hold the state enum (OFF, DECREASE, INCREASE, IDLE), the temp_comp codes, and the action codes.
REQ-029 Sub-module hvac_zone_fsm (one zone: FSM, dwell counter, optional fault bit) SHALL be instantiated NUM_ZONES times via a generate loop; the top SHALL contain only slicing and the any_active reduction.

Verification (NUM_ZONES=2, DWELL_CYCLES=4)
REQ-030 Reset, then power=11, temp_comp=10_01 -> after 1 edge zone0 INCREASE (action 10), zone1 DECREASE (action 01), any_active=1.
REQ-031 Zone0 in INCREASE, temp_comp[1:0] driven 10 one cycle after entry -> stays INCREASE for 4 cycles total, then IDLE for 1 cycle, then DECREASE; never INCREASE->DECREASE directly.
REQ-032 Zone1 in DECREASE, cycle 2 of dwell, power[1] dropped -> OFF on the next edge (action 11), dwell ignored; zone0 unaffected.
REQ-033 Both zones in INCREASE with dwell count 2, reset pulsed 1 cycle, then temp_comp=01_01 -> both enter INCREASE with counter 0 and need 4 full cycles before IDLE is reachable.
REQ-034 HVAC_FAULT_DETECT_EN defined, zone0 temp_comp=11 for 1 cycle with power=1 -> fault=01 stays set after temp_comp returns to 00, state unchanged by the 11; cleared only by reset; build without the macro -> compiles without the fault port.
